// File: rtl/airi5c_spi_master_engine.sv
// SPI master shift engine: pops TX FIFO words, shifts them out on SCLK/MOSI, pushes MISO words to RX FIFO.
// Define AIRI5C_SPI_RX_STALL_EN to hold off new frames while the RX FIFO is full.
module airi5c_spi_master_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_DIV_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic                     tx_empty,
    input  logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_pop,
    input  logic                     rx_full,
    output logic                     rx_push,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     sclk,
    output logic                     mosi,
    output logic                     ss_n,
    input  logic                     miso,
    output logic                     busy,
    output logic                     overflow
);
    localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_WIDTH-1:0]    r_tx_sr;
    logic [DATA_WIDTH-1:0]    r_rx_sr;
    logic [DATA_WIDTH-1:0]    r_rx_data;
    logic [CLK_DIV_WIDTH-1:0] r_div;
    logic [CLK_DIV_WIDTH-1:0] r_div_cnt;
    logic [EW-1:0]            r_edge_cnt;
    logic                     r_cpol;
    logic                     r_cpha;
    logic                     r_sclk;
    logic                     r_overflow;

    logic w_gate;
    logic w_start;
    logic w_tick;
    logic w_load;
    logic w_edge;
    logic w_done;
    logic w_push;
    logic w_sample;
    logic w_shift;
    logic w_ovf_set;

`ifdef AIRI5C_SPI_RX_STALL_EN
    assign w_gate    = ~rx_full;
    assign w_ovf_set = 1'b0;
`else
    assign w_gate    = 1'b1;
    assign w_ovf_set = (r_state == S_HOLD) & rx_full;
`endif

    assign w_start = enable & ~tx_empty & w_gate;
    assign w_tick  = (r_div_cnt == r_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_edge = 1'b0;
        w_done = 1'b0;
        w_push = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_SETUP;
                    w_load = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_next = S_SHIFT;
                    w_edge = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (r_edge_cnt == LAST_EDGE) begin
                        w_next = S_HOLD;
                        w_done = 1'b1;
                    end else begin
                        w_edge = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                w_push = ~rx_full;
                if (w_start) begin
                    w_next = S_SETUP;
                    w_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Even edges are leading; CPHA1 skips edge 0 since the MSB is preset in SETUP
    assign w_sample = w_edge & (r_cpha ? r_edge_cnt[0] : ~r_edge_cnt[0]);
    assign w_shift  = w_edge & (r_cpha ? (~r_edge_cnt[0] & (r_edge_cnt >= EW'(2)))
                                       : r_edge_cnt[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_sr    <= tx_data;
                r_rx_sr    <= '0;
                r_cpol     <= cpol;
                r_cpha     <= cpha;
                r_div      <= clk_div;
                r_sclk     <= cpol;
                r_div_cnt  <= '0;
                r_edge_cnt <= '0;
            end else begin
                if (r_state == S_SETUP || r_state == S_SHIFT)
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + CLK_DIV_WIDTH'(1);
                if (w_edge) begin
                    r_sclk     <= ~r_sclk;
                    r_edge_cnt <= r_edge_cnt + EW'(1);
                end
                if (w_sample) r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], miso};
                if (w_shift)  r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                if (w_done)   r_rx_data <= r_rx_sr;
            end
            if (!enable)        r_overflow <= 1'b0;
            else if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    assign tx_pop   = w_load & ~reset;
    assign rx_push  = w_push;
    assign rx_data  = r_rx_data;
    assign sclk     = reset ? 1'b0 : ((r_state == S_IDLE) ? cpol : r_sclk);
    assign mosi     = (r_state != S_IDLE) & r_tx_sr[DATA_WIDTH-1];
    assign ss_n     = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign overflow = r_overflow;
    // r_cpol only seeds r_sclk at load; kept for readability of the latched mode
    logic w_unused;
    assign w_unused = r_cpol;

endmodule

// File: doc/airi5c_spi_master_engine.md
# airi5c_spi_master_engine

Single-clock SPI master shift engine that drains the read port of the TX async FIFO and fills the write port of the RX async FIFO. Per frame it pops one word, drives SCLK/MOSI/SS_N in the selected CPOL/CPHA mode and samples MISO. It pushes the received word and chains frames back-to-back while TX data remains. It sits between the FIFOs and the SPI pads, in the FIFO domain clocked by `clk`.

## Interface
- `DATA_WIDTH`, 8, frame length in bits, MSB first
- `CLK_DIV_WIDTH`, 8, width of `clk_div`
- `clk` in 1: engine clock, also the FIFO TX-read / RX-write clock
- `reset` in 1: asynchronous, active-high
- `enable` in 1: permits starting new frames
- `cpol` in 1: SCLK idle level
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge
- `clk_div` in CLK_DIV_WIDTH: half-period H = clk_div+1 cycles
- `tx_empty` in 1: TX FIFO read-side empty flag
- `tx_data` in DATA_WIDTH: TX FIFO show-ahead head word
- `tx_pop` out 1: one-cycle pop strobe
- `rx_full` in 1: RX FIFO write-side full flag
- `rx_push` out 1: one-cycle push strobe
- `rx_data` out DATA_WIDTH: received word, valid while `rx_push`=1
- `sclk` out 1, `mosi` out 1, `ss_n` out 1, `miso` in 1: SPI pins
- `busy` out 1: state != IDLE
- `overflow` out 1: sticky RX-drop flag

## Operation
- Reset values: state IDLE, `sclk`=0, `mosi`=0, `ss_n`=1, `tx_pop`=0, `rx_push`=0, `rx_data`=0, `busy`=0, `overflow`=0, shift registers and counters 0. Reset mid-frame aborts immediately; the popped word is lost.
- `cpol`, `cpha` and `clk_div` are latched on each IDLE→SETUP and chain transition, and held for the frame. In IDLE, `sclk` follows live `cpol`.
- States:
  - IDLE: `ss_n`=1. If `enable` && !`tx_empty` (&& start gate, see Configuration), then assert `tx_pop` this cycle, load `tx_sr`←`tx_data`, go to SETUP.
  - SETUP: `ss_n`=0, `mosi`=`tx_sr[MSB]`. Lasts H cycles, then go to SHIFT.
  - SHIFT: toggle `sclk` every H cycles, for 2·DATA_WIDTH edges numbered e=0..2W-1; even = leading, odd = trailing.
    - CPHA0: sample (`rx_sr`←{`rx_sr`,`miso`}) on even edges; shift `tx_sr` on odd edges.
    - CPHA1: sample on odd edges; shift on even edges with e≥2.
    - After edge 2W-1, wait H cycles, then go to HOLD.
  - HOLD: one cycle.
    - `rx_data`←`rx_sr`; assert `rx_push` if !`rx_full`, else set `overflow`.
    - If `enable` && !`tx_empty` (&& start gate): pop, reload, go to SETUP with `ss_n` held low (chained).
    - Otherwise go to IDLE.
- `enable`=0 mid-frame: the frame completes, and no further frames start.
- `overflow` is cleared only by `reset` or by `enable`=0.
- Edge counter is ceil(log2(2W))+1 bits; divider counter is CLK_DIV_WIDTH bits, reloaded to 0 at each edge.

## Timing
- `tx_pop` occurs in the same cycle the start condition is observed, so FIFO `data_out` is captured at that edge. The FIFO's registered `tx_empty` needs no extra guard, because pops are ≥(2W+1)·H cycles apart.
- Frame length from `tx_pop` to `rx_push`: H·(2W+1)+1 cycles. For W=8, H=1: 18 cycles.
- First SCLK edge occurs H cycles after `ss_n` falls. After the last edge, SCLK is idle for ≥H cycles before `ss_n` rises.
- Chained frames: the gap between the last edge and the next SETUP is H+1 cycles, with `ss_n` low throughout.
- `rx_push` and `tx_pop` may coincide in HOLD.

## Configuration
- `AIRI5C_SPI_RX_STALL_EN` defined: start gate = !`rx_full`. The engine waits in IDLE/HOLD→IDLE until RX has room; `overflow` is never set.
- Undefined: start gate is always true. A word received while `rx_full`=1 is dropped and `overflow` is set.

## Test plan
- Mode 0, H=1, `miso` looped to `mosi`, TX 0xA5:
  - 8 rising SCLK edges.
  - `rx_push` with `rx_data`=0xA5 exactly 18 cycles after `tx_pop`.
  - `ss_n` high in IDLE afterwards.
- Mode 3 (cpol=1, cpha=1), `clk_div`=3, TX 0x3C, `miso` fixed 0xC3 pattern:
  - SCLK idle high, half-period 4 cycles.
  - MOSI changes only on falling edges.
  - `rx_data`=0xC3.
- TX FIFO holds 0x11, 0x22, 0x33:
  - three pops, `ss_n` continuously low.
  - three pushes in order 0x11, 0x22, 0x33 (loopback), then IDLE.
- `rx_full`=1 at frame end, TX holds 2 words:
  - Without the macro: no `rx_push`, `overflow`=1, second frame runs.
  - With the macro: second frame waits until `rx_full`=0, `overflow` stays 0.
- Assert `reset` at edge 5 of a frame:
  - All outputs take reset values asynchronously.
  - After release, the next frame starts cleanly with the next FIFO word.
- Drop `enable` mid-frame with TX non-empty:
  - Current frame completes and pushes.
  - No further pop; `overflow` cleared.
